// File: rtl/chaos_pkg.sv
// Shared types and defaults for the chaotic map iterator.
// State encoding plus map width and fixed-point perturbation constant.
package chaos_pkg;

  localparam int DATA_W_DEF = 32;
  localparam logic [31:0] PERTURB_DEF = 32'h9E3779B9;

  typedef enum logic [1:0] {
    IDLE,
    BURN,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/chaos_map_iterator.sv
// Sequential driver around the combinational chaotic map stage.
// Seeds the map, discards burn-in iterations, then streams N values.
module chaos_map_iterator
  import chaos_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W = 16,
  parameter int BURN_IN = 100,
  parameter logic [DATA_W-1:0] PERTURB = DATA_W'(PERTURB_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  input  logic [DATA_W-1:0] rfs_in,
  input  logic [DATA_W-1:0] rs_in,
  input  logic [CNT_W-1:0]  num_out,
  output logic [DATA_W-1:0] map_x0,
  output logic [DATA_W-1:0] map_rfs,
  output logic [DATA_W-1:0] map_rs,
  input  logic [DATA_W-1:0] map_x_next,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              stuck
);

  localparam logic [CNT_W-1:0] BURN_LAST = CNT_W'(BURN_IN - 1);

  state_t state, state_nx;

  logic [DATA_W-1:0] x_reg;
  logic [DATA_W-1:0] rfs_reg;
  logic [DATA_W-1:0] rs_reg;
  logic [CNT_W-1:0]  n_reg;
  logic [CNT_W-1:0]  burn_cnt;
  logic [CNT_W-1:0]  emit_cnt;
  logic              stuck_reg;

  logic              load;
  logic              step;
  logic              fixed;
  logic [DATA_W-1:0] next_x;

  // A fixed point would freeze the sequence; kick it out with PERTURB.
  assign fixed  = (map_x_next == x_reg);
  assign next_x = fixed ? (map_x_next ^ PERTURB) : map_x_next;

  assign map_x0   = x_reg;
  assign map_rfs  = rfs_reg;
  assign map_rs   = rs_reg;
  assign out_data = x_reg;
  assign stuck    = stuck_reg;

  always_comb begin
    state_nx  = state;
    load      = 1'b0;
    step      = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (num_out == '0)
            state_nx = DONE;
          else if (BURN_IN == 0)
            state_nx = EMIT;
          else
            state_nx = BURN;
        end
      end
      BURN: begin
        busy = 1'b1;
        step = 1'b1;
        if (burn_cnt == BURN_LAST)
          state_nx = EMIT;
      end
      EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          step = 1'b1;
          if (emit_cnt == n_reg - 1'b1)
            state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      x_reg     <= '0;
      rfs_reg   <= '0;
      rs_reg    <= '0;
      n_reg     <= '0;
      burn_cnt  <= '0;
      emit_cnt  <= '0;
      stuck_reg <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        x_reg     <= seed;
        rfs_reg   <= rfs_in;
        rs_reg    <= rs_in;
        n_reg     <= num_out;
        burn_cnt  <= '0;
        emit_cnt  <= '0;
        stuck_reg <= 1'b0;
      end else if (step) begin
        x_reg <= next_x;
        if (fixed)
          stuck_reg <= 1'b1;
        if (state == BURN)
          burn_cnt <= burn_cnt + 1'b1;
        else
          emit_cnt <= emit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/chaos_map_iterator.md
Name: chaos_map_iterator

Overview:
- Sequential driver placed directly around the combinational chaotic map stage (flipped-sine/sine blend).
- It holds the map state x, drives the map's x0/rfs/rs inputs from registers, and captures x_next on every iteration edge.
- It discards BURN_IN transient iterations, then emits N chaotic 32-bit values over a valid/ready stream to the downstream key/parameter consumer.
- It detects fixed points (x_next == x) and perturbs out of them.

Parameters:
- DATA_W, 32, width of map state and all map ports.
- CNT_W, 16, width of the output-count input and internal counters.
- BURN_IN, 100, iterations discarded after seeding (0 allowed, max 2^CNT_W-1).
- PERTURB, 32'h9E3779B9, XOR constant applied on fixed-point detection.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- seed  in  DATA_W  initial x0.
- rfs_in  in  DATA_W  flipped-sine ratio for this run.
- rs_in  in  DATA_W  sine ratio for this run.
- num_out  in  CNT_W  number of values to emit.
- map_x0  out  DATA_W  to map x0, equals x_reg.
- map_rfs  out  DATA_W  to map rfs, equals rfs_reg.
- map_rs  out  DATA_W  to map rs, equals rs_reg.
- map_x_next  in  DATA_W  combinational result from map.
- out_data  out  DATA_W  emitted value, equals x_reg.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high in BURN and EMIT.
- done  out  1  one-cycle pulse at run end.
- stuck  out  1  sticky fixed-point flag, cleared on start.

Behaviour:
- Reset (async, immediate): state=IDLE, x_reg/rfs_reg/rs_reg=0, counters=0, out_valid=0, busy=0, done=0, stuck=0. Reset mid-run aborts with no further outputs.
- IDLE: on edge with start=1, latch seed→x_reg, rfs_in→rfs_reg, rs_in→rs_reg, num_out→n_reg, clear counters and stuck.
  - num_out==0 → DONE.
  - else BURN_IN==0 → EMIT.
  - else → BURN.
- start is ignored outside IDLE.
- BURN: every edge, x_reg←next_x and burn_cnt++. After the BURN_IN-th update → EMIT.
- next_x = map_x_next, or (map_x_next ^ PERTURB) when map_x_next==x_reg. Detection also sets stuck. Applies in BURN and EMIT updates.
- EMIT: out_valid=1, out_data=x_reg.
  - On an edge with out_valid && out_ready: x_reg←next_x and emit_cnt++. If emit_cnt==n_reg-1 → DONE.
  - While out_ready=0: x_reg, out_data and out_valid hold stable; no iteration.
- Emitted sequence is x_B, x_B+1, …, x_B+N-1, where x_0=seed and B=BURN_IN.
- DONE: done=1 for exactly one cycle, out_valid=0, busy=0 → IDLE.
- Latency: start sampled at edge E0.
  - First out_valid high after edge E0+BURN_IN (E0 itself when BURN_IN=0).
  - With out_ready held high, one value per cycle.
  - done high in the cycle after the final handshake edge.
- Map arithmetic (including divide-by-zero) belongs to the map. The iterator treats map_x_next as opaque DATA_W bits, no width change.
- map_* outputs are driven purely from registers, so the combinational path is map only.

Decomposition:
- Package chaos_pkg: state enum (IDLE, BURN, EMIT, DONE), DATA_W default, PERTURB default constant.
- No sub-module inside this block. The chaotic map is instantiated beside it at the parent level and connected via the map_* ports.
- The bench substitutes a behavioural map stub.

Test Plan:
- Reset applied mid-cycle, async → out_valid=0, busy=0, done=0, stuck=0, map_x0=0 without waiting for a clock edge.
- Stub x_next=x+1; BURN_IN=4, seed=0x10, num_out=3, out_ready=1 → out_data 0x14, 0x15, 0x16 on consecutive cycles; done pulses once in the next cycle; busy falls.
- Same run, out_ready=0 for 5 cycles while 0x15 is presented → out_data stays 0x15, out_valid stays 1; 0x16 follows after ready returns; no skipped or duplicated values.
- Stub x_next=0x5 constant, seed=0x5, BURN_IN=1 → stuck=1; first out_data=0x5^0x9E3779B9=0x9E3779BC.
- num_out=0 with start → done high in the cycle after the start edge, out_valid never high, busy never high.
- start pulsed during EMIT with a different seed → ignored, current sequence unchanged. rst asserted during BURN → IDLE immediately; a new start then runs cleanly from its new seed.
